// File: rtl/occupancy_updater_if.sv
// rtl/occupancy_updater_if.sv - cell-update request and map-RAM signal bundle for occupancy_updater
interface occupancy_updater_if;
  // Request side, driven by the Bresenham line unit
  logic        write_enable;
  logic        cell_is_free;
  logic [7:0]  cell_x;
  logic [7:0]  cell_y;
  logic        clear_start;

  // Single-port synchronous map RAM
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  // Status back to the line unit
  logic        occupancy_busy;
  logic        overflow;

  // Updater side
  modport slave (
    input  write_enable, cell_is_free, cell_x, cell_y, clear_start, mem_rdata,
    output mem_addr, mem_we, mem_wdata, occupancy_busy, overflow
  );

  // Line unit plus RAM side
  modport master (
    output write_enable, cell_is_free, cell_x, cell_y, clear_start, mem_rdata,
    input  mem_addr, mem_we, mem_wdata, occupancy_busy, overflow
  );
endinterface

// File: rtl/occupancy_updater.sv
// rtl/occupancy_updater.sv - FIFO-buffered saturating log-odds RMW on the 256x256 map RAM; full-map clear built only with OCCUPANCY_CLEAR_EN
module occupancy_updater #(
  parameter int FIFO_DEPTH = 4,
  parameter int LO_OCC     = 9,
  parameter int LO_FREE    = 4,
  parameter int LO_MAX     = 127
) (
  input  logic               clock,
  input  logic               reset,
  occupancy_updater_if.slave bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]       FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic signed [8:0] SAT_HI     = 9'(LO_MAX);
  localparam logic signed [8:0] SAT_LO     = -SAT_HI;
  localparam logic signed [8:0] DELTA_OCC  = 9'(LO_OCC);
  localparam logic signed [8:0] DELTA_FREE = -(9'(LO_FREE));

`ifdef OCCUPANCY_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_CLEAR} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;
`endif

  typedef struct packed {
    logic       free;
    logic [7:0] y;
    logic [7:0] x;
  } req_t;

  state_e            state_q;
  logic [15:0]       mem_addr_q;
  logic              mem_we_q;
  logic              hold_free_q;
  logic              overflow_q, overflow_d;

  req_t              fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;

  logic              fifo_empty, fifo_full;
  logic              pop, push_ok, drop, clear_go;
  req_t              head;

  logic signed [8:0] rdata_ext, sum, sat;
  logic              unused_sat_msb;

`ifdef OCCUPANCY_CLEAR_EN
  logic [15:0]       clear_cnt_q;
  assign clear_go = (state_q == S_IDLE) && bus.clear_start;
`else
  logic              unused_clear_start;
  assign clear_go           = 1'b0;
  assign unused_clear_start = bus.clear_start;
`endif

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);
  assign head       = fifo_mem_q[rd_ptr_q];

  // READ is only ever entered with a non-empty FIFO, so it always pops
  assign pop     = (state_q == S_READ);
  // A full FIFO still takes a request when the head leaves on the same edge
  assign push_ok = bus.write_enable && (!fifo_full || pop);
  assign drop    = bus.write_enable && fifo_full && !pop;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky drop flag; a clear start wipes it, but a drop on that same edge is still recorded
  always_comb begin
    overflow_d = overflow_q;
    if (clear_go) overflow_d = 1'b0;
    if (drop)     overflow_d = 1'b1;
  end

  // FIFO storage; contents are only meaningful behind the pointers, so no reset
  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= '{free: bus.cell_is_free, y: bus.cell_y, x: bus.cell_x};
  end

  // FIFO control and overflow registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Saturating log-odds update of the cell read back during WRITE
  always_comb begin
    rdata_ext = {bus.mem_rdata[7], bus.mem_rdata};
    sum       = rdata_ext + (hold_free_q ? DELTA_FREE : DELTA_OCC);
    if (sum > SAT_HI)      sat = SAT_HI;
    else if (sum < SAT_LO) sat = SAT_LO;
    else                   sat = sum;
  end
  assign unused_sat_msb = sat[8];

  // Sequencer: address and write strobe are registered one state ahead so they
  // are stable for the whole state; write data must follow mem_rdata in WRITE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      hold_free_q <= 1'b0;
`ifdef OCCUPANCY_CLEAR_EN
      clear_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          mem_we_q <= 1'b0;
`ifdef OCCUPANCY_CLEAR_EN
          if (bus.clear_start) begin
            state_q     <= S_CLEAR;
            clear_cnt_q <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b1;
          end else
`endif
          if (!fifo_empty) begin
            state_q    <= S_READ;
            mem_addr_q <= {head.y, head.x};
          end
        end
        S_READ: begin
          // Address stays on the bus; only the update direction needs holding
          hold_free_q <= head.free;
          mem_we_q    <= 1'b1;
          state_q     <= S_WRITE;
        end
        S_WRITE: begin
          mem_we_q <= 1'b0;
          if (!fifo_empty) begin
            state_q    <= S_READ;
            mem_addr_q <= {head.y, head.x};
          end else begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
          end
        end
`ifdef OCCUPANCY_CLEAR_EN
        S_CLEAR: begin
          if (clear_cnt_q == 16'hFFFF) begin
            state_q     <= S_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            clear_cnt_q <= '0;
          end else begin
            clear_cnt_q <= clear_cnt_q + 16'd1;
            mem_addr_q  <= clear_cnt_q + 16'd1;
          end
        end
`endif
        default: begin
          state_q  <= S_IDLE;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_wdata      = (state_q == S_WRITE) ? sat[7:0] : 8'h00;
  assign bus.occupancy_busy = (state_q != S_IDLE) || !fifo_empty;
  assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_occupancy_updater.sv
// tb/tb_occupancy_updater.sv - directed self-checking bench for occupancy_updater
module tb_occupancy_updater;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  occupancy_updater_if bus ();

  occupancy_updater dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Map RAM model: synchronous read, write at the edge, every write logged
  logic [7:0]  ram [logic [15:0]];
  logic [15:0] wlog_addr [$];
  logic [7:0]  wlog_data [$];
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  always @(posedge clock) begin
    bus.mem_rdata <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : 8'h00;
    if (poke_en) ram[poke_addr] = poke_data;
    if (bus.mem_we) begin
      ram[bus.mem_addr] = bus.mem_wdata;
      wlog_addr.push_back(bus.mem_addr);
      wlog_data.push_back(bus.mem_wdata);
    end
  end

  int base;
  int n;
  int bad;
  logic [7:0] ovf_x [8] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h88};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  task automatic req(input logic free, input logic [7:0] x, input logic [7:0] y);
    bus.write_enable = 1'b1; bus.cell_is_free = free; bus.cell_x = x; bus.cell_y = y;
    @(negedge clock);
    bus.write_enable = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (bus.occupancy_busy !== 1'b0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [15:0] a, input logic [7:0] d);
    chk({tag, "_addr"}, (idx < wlog_addr.size()) ? 32'(wlog_addr[idx]) : 32'hDEAD, 32'(a));
    chk({tag, "_data"}, (idx < wlog_data.size()) ? 32'(wlog_data[idx]) : 32'hDEAD, 32'(d));
  endtask

  initial begin
    bus.write_enable = 1'b0;
    bus.cell_is_free = 1'b0;
    bus.cell_x       = '0;
    bus.cell_y       = '0;
    bus.clear_start  = 1'b0;

    // Reset and idle
    repeat (2) @(negedge clock);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_busy", bus.occupancy_busy, 0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("idle_we", bus.mem_we, 0);
    chk("idle_addr", bus.mem_addr, 0);
    chk("idle_wdata", bus.mem_wdata, 0);
    chk("idle_ovf", bus.overflow, 0);
    chk("idle_busy", bus.occupancy_busy, 0);
    chk("idle_nowrites", wlog_addr.size(), 0);

    poke(16'h0503, 8'h00);
    poke(16'h140A, 8'h83);
    poke(16'h0707, 8'h78);
    poke(16'h0909, 8'h05);
    poke(16'h0A0A, 8'h81);
    poke(16'h0B0B, 8'h7F);
    @(negedge clock);

    // Single occupied update on (x=3,y=5) with cycle-exact latency
    base = wlog_addr.size();
    req(1'b0, 8'd3, 8'd5);
    chk("lat_busy_rise", bus.occupancy_busy, 1);
    @(negedge clock);
    chk("lat_read_addr", bus.mem_addr, 16'h0503);
    chk("lat_read_we", bus.mem_we, 0);
    @(negedge clock);
    chk("lat_write_we", bus.mem_we, 1);
    chk("lat_write_addr", bus.mem_addr, 16'h0503);
    chk("lat_write_data", bus.mem_wdata, 8'h09);
    chk("lat_busy_write", bus.occupancy_busy, 1);
    @(negedge clock);
    chk("lat_busy_fall", bus.occupancy_busy, 0);
    chk("lat_we_fall", bus.mem_we, 0);
    chk("lat_nwrites", wlog_addr.size() - base, 1);

    // Saturation boundaries, back to back
    base = wlog_addr.size();
    req(1'b1, 8'h0A, 8'h14);
    req(1'b0, 8'h07, 8'h07);
    req(1'b1, 8'h09, 8'h09);
    req(1'b1, 8'h0A, 8'h0A);
    req(1'b0, 8'h0B, 8'h0B);
    wait_idle("sat_idle", 50);
    chk("sat_nwrites", wlog_addr.size() - base, 5);
    chk_write("sat_neg", base + 0, 16'h140A, 8'h81);
    chk_write("sat_pos", base + 1, 16'h0707, 8'h7F);
    chk_write("sat_free_small", base + 2, 16'h0909, 8'h01);
    chk_write("sat_at_min", base + 3, 16'h0A0A, 8'h81);
    chk_write("sat_at_max", base + 4, 16'h0B0B, 8'h7F);
    chk("sat_ovf", bus.overflow, 0);

    // Same cell twice in a row: second read must see the first write
    base = wlog_addr.size();
    req(1'b0, 8'h20, 8'h20);
    req(1'b0, 8'h20, 8'h20);
    wait_idle("same_idle", 50);
    chk_write("same_first", base + 0, 16'h2020, 8'h09);
    chk_write("same_second", base + 1, 16'h2020, 8'h12);

    // Ten requests spaced two cycles apart, alternating occupied/free
    base = wlog_addr.size();
    for (int i = 0; i < 10; i++) begin
      req(1'(i % 2), 8'(8'h40 + i), 8'h30);
      @(negedge clock);
    end
    wait_idle("paced_idle", 50);
    chk("paced_nwrites", wlog_addr.size() - base, 10);
    for (int i = 0; i < 10; i++)
      chk_write("paced", base + i, {8'h30, 8'(8'h40 + i)}, (i % 2) ? 8'hFC : 8'h09);
    chk("paced_ovf", bus.overflow, 0);

    // Ten consecutive requests: #7 and #9 find the FIFO full with no pop
    base = wlog_addr.size();
    for (int i = 0; i < 10; i++) req(1'b0, 8'(8'h80 + i), 8'h31);
    chk("burst_ovf", bus.overflow, 1);
    wait_idle("burst_idle", 60);
    chk("burst_nwrites", wlog_addr.size() - base, 8);
    for (int i = 0; i < 8; i++)
      chk_write("burst", base + i, {8'h31, ovf_x[i]}, 8'h09);
    repeat (5) @(negedge clock);
    chk("burst_ovf_sticky", bus.overflow, 1);

`ifdef OCCUPANCY_CLEAR_EN
    // Full clear with a request arriving part way through
    base = wlog_addr.size();
    bus.clear_start = 1'b1;
    @(negedge clock);
    bus.clear_start = 1'b0;
    chk("clr_ovf_cleared", bus.overflow, 0);
    chk("clr_we", bus.mem_we, 1);
    chk("clr_addr0", bus.mem_addr, 0);
    chk("clr_wdata", bus.mem_wdata, 0);
    repeat (100) @(negedge clock);
    req(1'b0, 8'h55, 8'h66);
    wait_idle("clr_idle", 70000);
    chk("clr_nwrites", wlog_addr.size() - base, 65537);
    bad = 0;
    for (int j = 0; j < 65536; j++)
      if (wlog_addr[base + j] !== 16'(j) || wlog_data[base + j] !== 8'h00) bad++;
    chk("clr_sequence_bad", bad, 0);
    chk_write("clr_late_req", base + 65536, 16'h6655, 8'h09);
    chk("clr_ovf_after", bus.overflow, 0);

    // Reset in the middle of a clear stops all writes
    base = wlog_addr.size();
    bus.clear_start = 1'b1;
    @(negedge clock);
    bus.clear_start = 1'b0;
    n = 0;
    while (bus.mem_addr !== 16'h1234 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk("abort_reach", 32'(n < 20000), 1);
    reset = 1'b1;
    #1;
    chk("abort_we", bus.mem_we, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("abort_nwrites", wlog_addr.size() - base, 32'h1234);
    chk("abort_busy", bus.occupancy_busy, 0);
`else
    // Without the clear feature, clear_start changes nothing
    base = wlog_addr.size();
    bus.clear_start = 1'b1;
    @(negedge clock);
    bus.clear_start = 1'b0;
    chk("noclr_busy", bus.occupancy_busy, 0);
    chk("noclr_ovf", bus.overflow, 1);
    repeat (5) @(negedge clock);
    chk("noclr_nwrites", wlog_addr.size() - base, 0);
    chk("noclr_we", bus.mem_we, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
